mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single mem_cntrl port between two requesters: req0 is the serial command
//   engine, req1 is a secondary master such as a display or DMA engine.
//   Arbitration is round-robin. The block issues exactly one mem_cntrl transaction at a time,
//   routes the read data and the completion back to the winner, and guards each transaction
//   with a watchdog.
// PARAMETERS
//   ADDR_WIDTH      24      mem_cntrl word address width
//   DATA_WIDTH      16      data word width
//   TIMEOUT_CYCLES  1024    max cycles from issue to mem_cplt before abort (>=2)
// PORTS
//   clk           in   1           system clock
//   rst           in   1           synchronous, active-high reset
//   reqN_req      in   1           (N=0,1) request; level, held until reqN_gnt
//   reqN_we       in   1           1=write, 0=read; sampled in gnt cycle
//   reqN_addr     in   ADDR_WIDTH  word address; sampled in gnt cycle
//   reqN_wdata    in   DATA_WIDTH  write data; sampled in gnt cycle
//   reqN_gnt      out  1           1-cycle pulse: command accepted
//   reqN_done     out  1           1-cycle pulse: transaction finished
//   reqN_err      out  1           valid with reqN_done; 1 = timed out
//   reqN_rdata    out  DATA_WIDTH  read data; valid with reqN_done, held until next done
//   mem_addr      out  ADDR_WIDTH  to mem_cntrl
//   mem_data_in   out  DATA_WIDTH  to mem_cntrl
//   mem_r_en      out  1           to mem_cntrl; 1-cycle pulse
//   mem_w_en      out  1           to mem_cntrl; 1-cycle pulse
//   mem_data_out  in   DATA_WIDTH  from mem_cntrl
//   mem_rdy       in   1           from mem_cntrl; idle and able to accept a command
//   mem_cplt      in   1           from mem_cntrl; 1-cycle pulse, read data valid / write done
//   timeout_err   out  1           sticky; set on any timeout, cleared only by rst
// BEHAVIOUR
//   Reset:
//     - state=IDLE; all gnt/done/err/en outputs 0; addr, data and rdata 0.
//     - timeout_err=0; rr pointer=0, so req0 wins the first tie.
//   Outputs: every output is registered.
//   State IDLE:
//     - When mem_rdy=1 and any reqN_req=1, pick the winner:
//       - Only one requesting: it wins.
//       - Both requesting: the one != last_grant wins.
//     - Same cycle: latch the winner's we/addr/wdata into mem_addr/mem_data_in, set
//       owner=winner, register reqN_gnt=1, go to ISSUE.
//     - mem_rdy=0: no grant, requests simply wait.
//   State ISSUE (1 cycle):
//     - Exactly one of mem_w_en/mem_r_en is 1 for this cycle.
//     - Command lands 2 cycles after the grant decision.
//     - last_grant<=owner; clear watchdog; go to WAIT.
//   State WAIT:
//     - Count cycles.
//     - On mem_cplt=1: register owner's rdata<=mem_data_out (reads only; writes leave rdata
//       unchanged), done=1, err=0, then go to IDLE.
//     - On count==TIMEOUT_CYCLES-1 without mem_cplt: done=1, err=1, rdata<=0,
//       timeout_err<=1, then go to IDLE.
//     - mem_cplt in the same cycle as expiry: completion wins, no error.
//   Per transaction: exactly one done pulse goes to the owner only; the other requester sees
//   no gnt, done or err.
//   Pipelining: a new grant cannot occur in the cycle done is registered. Earliest re-grant
//   is the following cycle, after IDLE re-evaluates.
//   Ignored inputs:
//     - mem_cplt while in IDLE or ISSUE.
//     - reqN_req deasserted before gnt: request withdrawn, nothing issued.
//     - reqN_req held high after gnt: treated as a new request.
//   Reset mid-transaction: the transaction is abandoned, no done pulse is produced, and all
//   outputs return to their reset values on the next edge.
// TESTING
//   T1 req0 write addr=0x000010 data=0xBEEF, mem_cplt 5 cycles after w_en
//      -> gnt0 1 cycle; w_en 2 cycles after grant decision; done0=1, err0=0.
//   T2 req1 read addr=0x000010 after T1, model returns 0xBEEF
//      -> r_en pulse; done1 with rdata1=0xBEEF; no req0 activity.
//   T3 req0 and req1 asserted together, continuously, right after reset
//      -> grants alternate 0,1,0,1; never two commands without an intervening mem_cplt.
//   T4 mem_rdy held 0 for 20 cycles while req1 is high
//      -> no gnt, no en; grant in the first IDLE cycle after mem_rdy=1.
//   T5 TIMEOUT_CYCLES=8, model never asserts mem_cplt
//      -> done=1, err=1, rdata=0, timeout_err=1 stays set; the next request is served
//         normally.
//   T6 assert rst during WAIT
//      -> all outputs 0 next cycle; no done pulse; subsequent req0 served and won by req0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one mem_cntrl port between two requesters.
// One transaction is in flight at a time, and each one is guarded by a watchdog.
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 24,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_req,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  req0_gnt,
   output logic                  req0_done,
   output logic                  req0_err,
   output logic [DATA_WIDTH-1:0] req0_rdata,
   input  logic                  req1_req,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  req1_gnt,
   output logic                  req1_done,
   output logic                  req1_err,
   output logic [DATA_WIDTH-1:0] req1_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_r_en,
   output logic                  mem_w_en,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic                  mem_rdy,
   input  logic                  mem_cplt,
   output logic                  timeout_err,
   output logic [1:0]            dbg_state
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t           state_q;
   logic             owner_q;
   logic             prio_q;   // requester that wins the next tie
   logic             we_q;
   logic [CNT_W-1:0] cnt_q;
   logic             win_id;
   logic             any_req;

   assign any_req   = req0_req | req1_req;
   assign dbg_state = state_q;

   always_comb begin
      win_id = req1_req;
      if (req0_req && req1_req) begin
         win_id = prio_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         prio_q      <= 1'b0;
         we_q        <= 1'b0;
         cnt_q       <= '0;
         req0_gnt    <= 1'b0;
         req0_done   <= 1'b0;
         req0_err    <= 1'b0;
         req0_rdata  <= '0;
         req1_gnt    <= 1'b0;
         req1_done   <= 1'b0;
         req1_err    <= 1'b0;
         req1_rdata  <= '0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         mem_r_en    <= 1'b0;
         mem_w_en    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         req0_gnt  <= 1'b0;
         req1_gnt  <= 1'b0;
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         req0_err  <= 1'b0;
         req1_err  <= 1'b0;
         mem_r_en  <= 1'b0;
         mem_w_en  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mem_rdy && any_req) begin
                  owner_q <= win_id;
                  if (win_id) begin
                     we_q        <= req1_we;
                     mem_addr    <= req1_addr;
                     mem_data_in <= req1_wdata;
                     req1_gnt    <= 1'b1;
                  end else begin
                     we_q        <= req0_we;
                     mem_addr    <= req0_addr;
                     mem_data_in <= req0_wdata;
                     req0_gnt    <= 1'b1;
                  end
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               mem_w_en <= we_q;
               mem_r_en <= ~we_q;
               prio_q   <= ~owner_q;
               cnt_q    <= '0;
               state_q  <= WAIT;
            end
            WAIT: begin
               // A completion arriving on the expiry cycle still counts as success.
               if (mem_cplt) begin
                  if (owner_q) begin
                     req1_done <= 1'b1;
                     if (!we_q) req1_rdata <= mem_data_out;
                  end else begin
                     req0_done <= 1'b1;
                     if (!we_q) req0_rdata <= mem_data_out;
                  end
                  state_q <= IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  if (owner_q) begin
                     req1_done  <= 1'b1;
                     req1_err   <= 1'b1;
                     req1_rdata <= '0;
                  end else begin
                     req0_done  <= 1'b1;
                     req0_err   <= 1'b1;
                     req0_rdata <= '0;
                  end
                  timeout_err <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a memory model answers commands, and a monitor checks
// grants, commands and completions against queues that the test sequence fills.
module tb_mem_arbiter;
   localparam int AW = 24;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_req = 1'b0, req0_we = 1'b0;
   logic [AW-1:0] req0_addr = '0;
   logic [DW-1:0] req0_wdata = '0;
   logic          req1_req = 1'b0, req1_we = 1'b0;
   logic [AW-1:0] req1_addr = '0;
   logic [DW-1:0] req1_wdata = '0;
   logic          req0_gnt, req0_done, req0_err, req1_gnt, req1_done, req1_err;
   logic [DW-1:0] req0_rdata, req1_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic          mem_r_en, mem_w_en, timeout_err;
   logic [DW-1:0] mem_data_out = '0;
   logic          mem_rdy;
   logic          mem_cplt = 1'b0;
   logic [1:0]    dbg_state;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req0_req(req0_req), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_gnt(req0_gnt), .req0_done(req0_done), .req0_err(req0_err), .req0_rdata(req0_rdata),
      .req1_req(req1_req), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_gnt(req1_gnt), .req1_done(req1_done), .req1_err(req1_err), .req1_rdata(req1_rdata),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .mem_data_out(mem_data_out), .mem_rdy(mem_rdy), .mem_cplt(mem_cplt),
      .timeout_err(timeout_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // grant entry {id, we, addr, wdata}; done entry {id, err, rdata}
   logic [AW+DW+1:0] gnt_q[$];
   logic [DW+1:0]    exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic          rdy_en = 1'b1;
   logic          drop = 1'b0;
   logic          busy = 1'b0;
   int            lat = 3;
   int            cd = 0;
   logic          pend_we = 1'b0;
   logic [AW-1:0] pend_addr = '0;
   logic [DW-1:0] pend_data = '0;
   logic [DW-1:0] mem_arr [logic [AW-1:0]];

   assign mem_rdy = rdy_en && !busy;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         mem_cplt = 1'b0;
         if (rst) begin
            busy = 1'b0;
            cd   = 0;
         end else begin
            if (busy) begin
               cd--;
               if (cd == 0) begin
                  mem_cplt = 1'b1;
                  busy     = 1'b0;
                  if (pend_we) mem_arr[pend_addr] = pend_data;
                  else         mem_data_out = mem_arr[pend_addr];
               end
            end
            if (mem_w_en || mem_r_en) begin
               check("cmd_overlap", {31'd0, busy}, 64'd0);
               if (!drop) begin
                  busy      = 1'b1;
                  cd        = lat;
                  pend_we   = mem_w_en;
                  pend_addr = mem_addr;
                  pend_data = mem_data_in;
               end
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic             en_due = 1'b0;
   logic [AW+DW+1:0] cur_g = '0;
   logic [DW+1:0]    cur_d = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            en_due = 1'b0;
         end else begin
            if (en_due) begin
               check("cmd_dir", {mem_w_en, mem_r_en}, cur_g[AW+DW] ? 2'b10 : 2'b01);
               check("cmd_addr", mem_addr, cur_g[AW+DW-1:DW]);
               if (cur_g[AW+DW]) check("cmd_wdata", mem_data_in, cur_g[DW-1:0]);
               en_due = 1'b0;
            end else if (mem_w_en || mem_r_en) begin
               check("spurious_cmd", {mem_w_en, mem_r_en}, 2'b00);
            end
            if (req0_gnt || req1_gnt) begin
               if (gnt_q.size() == 0) begin
                  check("unexpected_gnt", {req1_gnt, req0_gnt}, 2'b00);
               end else begin
                  cur_g = gnt_q.pop_front();
                  check("gnt_onehot", {req1_gnt, req0_gnt}, cur_g[AW+DW+1] ? 2'b10 : 2'b01);
                  en_due = 1'b1;
               end
            end
            if (req0_done || req1_done) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", {req1_done, req0_done}, 2'b00);
               end else begin
                  cur_d = exp_q.pop_front();
                  check("done_onehot", {req1_done, req0_done}, cur_d[DW+1] ? 2'b10 : 2'b01);
                  check("done_err", cur_d[DW+1] ? req1_err : req0_err, cur_d[DW]);
                  check("done_rdata", cur_d[DW+1] ? req1_rdata : req0_rdata, cur_d[DW-1:0]);
               end
            end
            if ((req0_err && !req0_done) || (req1_err && !req1_done)) begin
               check("err_without_done", {req1_err, req0_err}, 2'b00);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic expect_txn(input logic id, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input logic err, input logic [DW-1:0] rd);
      gnt_q.push_back({id, we, addr, wd});
      exp_q.push_back({id, err, rd});
   endtask

   task automatic drive(input logic id, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd);
      int n = 0;
      if (id) begin
         req1_we = we; req1_addr = addr; req1_wdata = wd; req1_req = 1'b1;
      end else begin
         req0_we = we; req0_addr = addr; req0_wdata = wd; req0_req = 1'b1;
      end
      do begin
         @(negedge clk);
         n++;
      end while (!(id ? req1_gnt : req0_gnt) && n < 300);
      if (n >= 300) check("gnt_wait_timeout", 64'd0, 64'd1);
      if (id) req1_req = 1'b0;
      else    req0_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || gnt_q.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("drain_timeout", exp_q.size() + gnt_q.size(), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt_done_err"}, {req0_gnt, req0_done, req0_err, req1_gnt, req1_done, req1_err}, 6'd0);
      check({tag, "_mem_en"}, {mem_r_en, mem_w_en}, 2'b00);
      check({tag, "_mem_addr"}, mem_addr, 24'd0);
      check({tag, "_mem_data_in"}, mem_data_in, 16'd0);
      check({tag, "_rdata"}, {req0_rdata, req1_rdata}, 32'd0);
      check({tag, "_timeout_err"}, timeout_err, 1'b0);
      check({tag, "_state"}, dbg_state, 2'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int k;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // T3: both requesting continuously, grants alternate from req0
      expect_txn(1'b0, 1'b1, 24'h000100, 16'h1111, 1'b0, 16'h0000);
      expect_txn(1'b1, 1'b1, 24'h000200, 16'h2222, 1'b0, 16'h0000);
      expect_txn(1'b0, 1'b0, 24'h000100, 16'h0000, 1'b0, 16'h1111);
      expect_txn(1'b1, 1'b0, 24'h000200, 16'h0000, 1'b0, 16'h2222);
      fork
         begin
            drive(1'b0, 1'b1, 24'h000100, 16'h1111);
            drive(1'b0, 1'b0, 24'h000100, 16'h0000);
         end
         begin
            drive(1'b1, 1'b1, 24'h000200, 16'h2222);
            drive(1'b1, 1'b0, 24'h000200, 16'h0000);
         end
      join
      wait_idle();

      // T1: req0 write, completion 5 cycles after the command
      lat = 5;
      expect_txn(1'b0, 1'b1, 24'h000010, 16'hBEEF, 1'b0, 16'h1111);
      drive(1'b0, 1'b1, 24'h000010, 16'hBEEF);
      wait_idle();

      // T2: req1 reads back the same word
      lat = 3;
      expect_txn(1'b1, 1'b0, 24'h000010, 16'h0000, 1'b0, 16'hBEEF);
      drive(1'b1, 1'b0, 24'h000010, 16'h0000);
      wait_idle();

      // T4: mem_rdy held low for 20 cycles
      rdy_en = 1'b0;
      expect_txn(1'b1, 1'b0, 24'h000200, 16'h0000, 1'b0, 16'h2222);
      fork
         drive(1'b1, 1'b0, 24'h000200, 16'h0000);
      join_none
      repeat (20) begin
         @(negedge clk);
         check("t4_blocked", {req1_gnt, mem_r_en | mem_w_en}, 2'b00);
      end
      rdy_en = 1'b1;
      @(negedge clk);
      check("t4_first_idle_gnt", req1_gnt, 1'b1);
      wait_idle();

      // T5: no completion, watchdog expires
      drop = 1'b1;
      expect_txn(1'b0, 1'b0, 24'h000100, 16'h0000, 1'b1, 16'h0000);
      fork
         drive(1'b0, 1'b0, 24'h000100, 16'h0000);
      join_none
      k = 0;
      while (!mem_r_en && k < 50) begin
         @(negedge clk);
         k++;
      end
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!req0_done && k < 50);
      check("t5_timeout_latency", k, TO);
      check("t5_timeout_err_set", timeout_err, 1'b1);
      drop = 1'b0;
      wait_idle();
      expect_txn(1'b1, 1'b1, 24'h000300, 16'h3333, 1'b0, 16'h2222);
      drive(1'b1, 1'b1, 24'h000300, 16'h3333);
      wait_idle();
      check("t5_timeout_err_sticky", timeout_err, 1'b1);

      // T6: reset during WAIT abandons the transaction
      lat = 5;
      gnt_q.push_back({1'b0, 1'b0, 24'h000010, 16'h0000});
      drive(1'b0, 1'b0, 24'h000010, 16'h0000);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("t6");
      rst = 1'b0;
      repeat (8) @(negedge clk);
      lat = 3;
      expect_txn(1'b0, 1'b0, 24'h000010, 16'h0000, 1'b0, 16'hBEEF);
      expect_txn(1'b1, 1'b0, 24'h000300, 16'h0000, 1'b0, 16'h3333);
      fork
         drive(1'b0, 1'b0, 24'h000010, 16'h0000);
         drive(1'b1, 1'b0, 24'h000300, 16'h0000);
      join
      wait_idle();

      check("gnt_queue_empty", gnt_q.size(), 64'd0);
      check("exp_queue_empty", exp_q.size(), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
